// File: rtl/tmem_arb_pkg.sv
// Shared constants and types for the tagged-memory bus arbiter.
// Word address, data and tag widths, FSM states and the latched request record.
package tmem_arb_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned TAG_W  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StRead,
    StRdWait,
    StWrite,
    StLocked
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [TAG_W-1:0]  wtag;
  } mem_req_t;

endpackage

// File: rtl/tmem_arbiter_if.sv
// Requester ports plus the multiplexed tagged-memory bus, bundled for the arbiter.
// slave: the arbiter side; master: the requesters and the memory.
interface tmem_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  import tmem_arb_pkg::*;

  logic [NREQ-1:0]             req;
  logic [NREQ-1:0]             we;
  logic [NREQ-1:0]             lock;
  logic [NREQ-1:0][ADDR_W-1:0] addr;
  logic [NREQ-1:0][DATA_W-1:0] wdata;
  logic [NREQ-1:0][TAG_W-1:0]  wtag;
  logic [NREQ-1:0]             done;
  logic [DATA_W-1:0]           rdata;
  logic [TAG_W-1:0]            rtag;
  logic [NREQ-1:0]             grant;
  logic                        lock_err;

  logic [DATA_W-1:0]           mem_ad;
  logic [TAG_W-1:0]            mem_tag;
  logic                        mem_astb;
  logic                        mem_atomic;
  logic                        mem_rd;
  logic                        mem_wr;
  logic [DATA_W-1:0]           mem_data;
  logic [TAG_W-1:0]            mem_itag;

  modport slave (
    input  req, we, lock, addr, wdata, wtag, mem_data, mem_itag,
    output done, rdata, rtag, grant, lock_err,
    output mem_ad, mem_tag, mem_astb, mem_atomic, mem_rd, mem_wr
  );

  modport master (
    output req, we, lock, addr, wdata, wtag, mem_data, mem_itag,
    input  done, rdata, rtag, grant, lock_err,
    input  mem_ad, mem_tag, mem_astb, mem_atomic, mem_rd, mem_wr
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module rr_picker #(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         winner_o,
  output logic                    valid_o
);

  localparam int unsigned PtrW = $clog2(NREQ);

  logic [PtrW-1:0] idx;
  logic            found;

  always_comb begin
    winner_o = '0;
    idx      = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PtrW'((32'(ptr_i) + k) % NREQ);
      if (!found && req_i[idx]) begin
        winner_o[idx] = 1'b1;
        found         = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/tmem_arbiter.sv
// Round-robin arbiter sharing the tagged-memory bus between NREQ requesters, sequencing
// address and data phases and holding the grant across locked read-modify-write.
module tmem_arbiter
  import tmem_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned LOCK_TMO = 64
) (
  input logic           clk,
  input logic           reset,
  tmem_arbiter_if.slave bus
);

  localparam int unsigned PtrW = $clog2(NREQ);
  localparam int unsigned RdW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned TmoW = (LOCK_TMO > 1) ? $clog2(LOCK_TMO) : 1;

  arb_state_t        state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  mem_req_t          cur_q, cur_d;
  logic              locked_q, locked_d;
  logic [RdW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [TAG_W-1:0]  rtag_q, rtag_d;
  logic              lock_err_q, lock_err_d;

  logic [NREQ-1:0]   req_live;
  logic [NREQ-1:0]   winner;
  logic              win_valid;
  logic [PtrW-1:0]   win_idx;
  logic [PtrW-1:0]   src_idx;
  mem_req_t          src;
  logic              owner_req;

  logic [DATA_W-1:0] mem_ad;
  logic [TAG_W-1:0]  mem_tag;
  logic              mem_astb, mem_atomic, mem_rd, mem_wr;

  // A requester still holds req during its done cycle; that is not a new request.
  assign req_live  = bus.req & ~done_q;
  assign owner_req = req_live[owner_q];

  rr_picker #(
    .NREQ (NREQ)
  ) u_rr_picker (
    .req_i    (req_live),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .valid_o  (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner[i]) win_idx = PtrW'(i);
    end
  end

  always_comb begin
    src_idx   = (state_q == StLocked) ? owner_q : win_idx;
    src.we    = bus.we[src_idx];
    src.lock  = bus.lock[src_idx];
    src.addr  = bus.addr[src_idx];
    src.wdata = bus.wdata[src_idx];
    src.wtag  = bus.wtag[src_idx];
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    done_d     = '0;
    cur_d      = cur_q;
    locked_d   = locked_q;
    rd_cnt_d   = rd_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    rdata_d    = rdata_q;
    rtag_d     = rtag_q;
    lock_err_d = 1'b0;
    mem_ad     = '0;
    mem_tag    = '0;
    mem_astb   = 1'b0;
    mem_atomic = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;

    unique case (state_q)
      StIdle: begin
        grant_d = '0;
        if (win_valid) begin
          cur_d   = src;
          grant_d = winner;
          owner_d = win_idx;
          ptr_d   = (win_idx == PtrW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          state_d = StAddr;
        end
      end
      StAddr: begin
        mem_astb   = 1'b1;
        mem_ad     = {{(DATA_W - ADDR_W){1'b0}}, cur_q.addr};
        mem_atomic = cur_q.lock | locked_q;
        state_d    = cur_q.we ? StWrite : StRead;
      end
      StRead: begin
        mem_rd   = 1'b1;
        rd_cnt_d = RdW'(RD_LAT - 1);
        state_d  = StRdWait;
      end
      StRdWait: begin
        if (rd_cnt_q == '0) begin
          rdata_d = bus.mem_data;
          rtag_d  = bus.mem_itag;
          done_d  = grant_q;
          if (cur_q.lock) begin
            locked_d  = 1'b1;
            tmo_cnt_d = '0;
            state_d   = StLocked;
          end else begin
            locked_d = 1'b0;
            grant_d  = '0;
            state_d  = StIdle;
          end
        end else begin
          rd_cnt_d = rd_cnt_q - 1'b1;
        end
      end
      StWrite: begin
        mem_wr     = 1'b1;
        mem_ad     = cur_q.wdata;
        mem_tag    = cur_q.wtag;
        mem_atomic = locked_q;
        done_d     = grant_q;
        locked_d   = 1'b0;
        grant_d    = '0;
        state_d    = StIdle;
      end
      StLocked: begin
        if (owner_req) begin
          cur_d     = src;
          tmo_cnt_d = '0;
          state_d   = StAddr;
        end else if (tmo_cnt_q == TmoW'(LOCK_TMO - 1)) begin
          lock_err_d = 1'b1;
          locked_d   = 1'b0;
          grant_d    = '0;
          state_d    = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      cur_q      <= '0;
      locked_q   <= 1'b0;
      rd_cnt_q   <= '0;
      tmo_cnt_q  <= '0;
      rdata_q    <= '0;
      rtag_q     <= '0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      cur_q      <= cur_d;
      locked_q   <= locked_d;
      rd_cnt_q   <= rd_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      rdata_q    <= rdata_d;
      rtag_q     <= rtag_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign bus.done       = done_q;
  assign bus.rdata      = rdata_q;
  assign bus.rtag       = rtag_q;
  assign bus.grant      = grant_q;
  assign bus.lock_err   = lock_err_q;
  assign bus.mem_ad     = mem_ad;
  assign bus.mem_tag    = mem_tag;
  assign bus.mem_astb   = mem_astb;
  assign bus.mem_atomic = mem_atomic;
  assign bus.mem_rd     = mem_rd;
  assign bus.mem_wr     = mem_wr;

endmodule

// File: tb/tb_tmem_arbiter.sv
// Directed bench for tmem_arbiter: NREQ=2, RD_LAT=1, LOCK_TMO=4, with a one-cycle memory.
module tb_tmem_arbiter;
  import tmem_arb_pkg::*;

  localparam int unsigned NREQ = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              rd_dly;
  logic [DATA_W-1:0] mem_val;
  logic [TAG_W-1:0]  mem_tagv;
  int unsigned       passed = 0;
  int unsigned       total  = 0;

  tmem_arbiter_if #(.NREQ(NREQ)) bus ();

  tmem_arbiter #(
    .NREQ     (NREQ),
    .RD_LAT   (1),
    .LOCK_TMO (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory answers exactly one cycle after mem_rd; junk otherwise exposes mistimed capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_dly <= 1'b0;
    else       rd_dly <= bus.mem_rd;
  end
  assign bus.mem_data = rd_dly ? mem_val : 64'hBAD0_BAD0_BAD0_BAD0;
  assign bus.mem_itag = rd_dly ? mem_tagv : 8'hEE;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req   = '0;
    bus.we    = '0;
    bus.lock  = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.wtag  = '0;
  endtask

  task automatic test_reset();
    clear_reqs();
    mem_val  = '0;
    mem_tagv = '0;
    reset    = 1'b1;
    #3;
    total++;
    if (bus.grant !== 2'b00 || bus.done !== 2'b00 || bus.lock_err !== 1'b0)
      $display("FAIL reset_ctl: got grant=%b done=%b lock_err=%b want 00 00 0",
               bus.grant, bus.done, bus.lock_err);
    else passed++;
    total++;
    if ({bus.mem_astb, bus.mem_rd, bus.mem_wr, bus.mem_atomic} !== 4'b0000 ||
        bus.mem_ad !== 64'h0 || bus.rdata !== 64'h0)
      $display("FAIL reset_bus: got strobes=%b ad=%h rdata=%h want 0000 0 0",
               {bus.mem_astb, bus.mem_rd, bus.mem_wr, bus.mem_atomic}, bus.mem_ad, bus.rdata);
    else passed++;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Both requesters read continuously from a fresh pointer: grants alternate 0,1,0,1.
  task automatic test_back_to_back();
    logic [NREQ-1:0] exp;
    bus.req     = 2'b11;
    bus.addr[0] = 20'h00010;
    bus.addr[1] = 20'h00020;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      total++;
      if (bus.grant !== exp || bus.mem_astb !== 1'b1)
        $display("FAIL b2b_grant[%0d]: got grant=%b astb=%b want %b 1",
                 i, bus.grant, bus.mem_astb, exp);
      else passed++;
      mem_val  = 64'h1111_0000_0000_0000 + 64'(i);
      mem_tagv = 8'h10 + 8'(i);
      tick();
      tick();
      tick();
      total++;
      if (bus.done !== exp || bus.rdata !== mem_val || bus.rtag !== mem_tagv)
        $display("FAIL b2b_done[%0d]: got done=%b rdata=%h rtag=%h want %b %h %h",
                 i, bus.done, bus.rdata, bus.rtag, exp, mem_val, mem_tagv);
      else passed++;
      if (i == 3) bus.req = 2'b00;
    end
    tick();
    total++;
    if (bus.done !== 2'b00 || bus.grant !== 2'b00)
      $display("FAIL b2b_idle: got done=%b grant=%b want 00 00", bus.done, bus.grant);
    else passed++;
  endtask

  task automatic test_single_write();
    bus.req[0]   = 1'b1;
    bus.we[0]    = 1'b1;
    bus.addr[0]  = 20'h00123;
    bus.wdata[0] = 64'hDEAD_BEEF_0123_4567;
    bus.wtag[0]  = 8'h34;
    tick();
    total++;
    if (bus.mem_astb !== 1'b1 || bus.mem_ad !== 64'h123 || bus.grant !== 2'b01 ||
        bus.mem_atomic !== 1'b0)
      $display("FAIL wr_addr: got astb=%b ad=%h grant=%b atomic=%b want 1 123 01 0",
               bus.mem_astb, bus.mem_ad, bus.grant, bus.mem_atomic);
    else passed++;
    tick();
    total++;
    if (bus.mem_wr !== 1'b1 || bus.mem_astb !== 1'b0 || bus.mem_rd !== 1'b0 ||
        bus.mem_ad !== 64'hDEAD_BEEF_0123_4567 || bus.mem_tag !== 8'h34)
      $display("FAIL wr_data: got wr=%b astb=%b rd=%b ad=%h tag=%h want 1 0 0 deadbeef01234567 34",
               bus.mem_wr, bus.mem_astb, bus.mem_rd, bus.mem_ad, bus.mem_tag);
    else passed++;
    tick();
    total++;
    if (bus.done !== 2'b01 || bus.mem_wr !== 1'b0 || bus.grant !== 2'b00)
      $display("FAIL wr_done: got done=%b wr=%b grant=%b want 01 0 00",
               bus.done, bus.mem_wr, bus.grant);
    else passed++;
    total++;
    if (bus.rdata !== 64'h1111_0000_0000_0003)
      $display("FAIL wr_rdata_hold: got %h want 1111000000000003", bus.rdata);
    else passed++;
    clear_reqs();
    tick();
    total++;
    if (bus.done !== 2'b00 || bus.mem_astb !== 1'b0)
      $display("FAIL wr_after: got done=%b astb=%b want 00 0", bus.done, bus.mem_astb);
    else passed++;
  endtask

  task automatic test_single_read();
    bus.req[0]  = 1'b1;
    bus.addr[0] = 20'h00456;
    mem_val     = 64'h0000_0000_CAFE_F00D;
    mem_tagv    = 8'h05;
    tick();
    total++;
    if (bus.mem_astb !== 1'b1 || bus.mem_ad !== 64'h456 || bus.grant !== 2'b01)
      $display("FAIL rd_addr: got astb=%b ad=%h grant=%b want 1 456 01",
               bus.mem_astb, bus.mem_ad, bus.grant);
    else passed++;
    tick();
    total++;
    if (bus.mem_rd !== 1'b1 || bus.mem_ad !== 64'h0 || bus.mem_wr !== 1'b0)
      $display("FAIL rd_strobe: got rd=%b ad=%h wr=%b want 1 0 0",
               bus.mem_rd, bus.mem_ad, bus.mem_wr);
    else passed++;
    tick();
    total++;
    if (bus.done !== 2'b00 || bus.mem_rd !== 1'b0)
      $display("FAIL rd_wait: got done=%b rd=%b want 00 0", bus.done, bus.mem_rd);
    else passed++;
    tick();
    total++;
    if (bus.done !== 2'b01 || bus.rdata !== 64'h0000_0000_CAFE_F00D || bus.rtag !== 8'h05)
      $display("FAIL rd_done: got done=%b rdata=%h rtag=%h want 01 00000000cafef00d 05",
               bus.done, bus.rdata, bus.rtag);
    else passed++;
    clear_reqs();
    tick();
  endtask

  // Pointer is 1 here, so requester 1 wins the simultaneous request; 0 waits out the lock.
  task automatic test_atomic();
    bus.req      = 2'b11;
    bus.lock[1]  = 1'b1;
    bus.addr[1]  = 20'h808c6;
    bus.we[0]    = 1'b1;
    bus.addr[0]  = 20'h00077;
    bus.wdata[0] = 64'h0707;
    mem_val      = 64'h0000_00A1_0000_00A1;
    mem_tagv     = 8'hA1;
    tick();
    total++;
    if (bus.grant !== 2'b10 || bus.mem_atomic !== 1'b1 || bus.mem_ad !== 64'h808c6)
      $display("FAIL at_rd_addr: got grant=%b atomic=%b ad=%h want 10 1 808c6",
               bus.grant, bus.mem_atomic, bus.mem_ad);
    else passed++;
    tick();
    tick();
    tick();
    total++;
    if (bus.done !== 2'b10 || bus.grant !== 2'b10 || bus.rdata !== 64'h0000_00A1_0000_00A1)
      $display("FAIL at_rd_done: got done=%b grant=%b rdata=%h want 10 10 000000a1000000a1",
               bus.done, bus.grant, bus.rdata);
    else passed++;
    bus.we[1]    = 1'b1;
    bus.lock[1]  = 1'b0;
    bus.wdata[1] = 64'h55;
    bus.wtag[1]  = 8'h66;
    tick();
    total++;
    if (bus.grant !== 2'b10 || bus.mem_astb !== 1'b0)
      $display("FAIL at_locked: got grant=%b astb=%b want 10 0", bus.grant, bus.mem_astb);
    else passed++;
    tick();
    total++;
    if (bus.grant !== 2'b10 || bus.mem_astb !== 1'b1 || bus.mem_atomic !== 1'b1)
      $display("FAIL at_wr_addr: got grant=%b astb=%b atomic=%b want 10 1 1",
               bus.grant, bus.mem_astb, bus.mem_atomic);
    else passed++;
    tick();
    total++;
    if (bus.mem_wr !== 1'b1 || bus.mem_ad !== 64'h55 || bus.mem_tag !== 8'h66 ||
        bus.mem_atomic !== 1'b1)
      $display("FAIL at_wr_data: got wr=%b ad=%h tag=%h atomic=%b want 1 55 66 1",
               bus.mem_wr, bus.mem_ad, bus.mem_tag, bus.mem_atomic);
    else passed++;
    tick();
    total++;
    if (bus.done !== 2'b10 || bus.grant !== 2'b00 || bus.rdata !== 64'h0000_00A1_0000_00A1)
      $display("FAIL at_wr_done: got done=%b grant=%b rdata=%h want 10 00 000000a1000000a1",
               bus.done, bus.grant, bus.rdata);
    else passed++;
    bus.req[1] = 1'b0;
    tick();
    total++;
    if (bus.grant !== 2'b01 || bus.mem_atomic !== 1'b0 || bus.mem_ad !== 64'h77)
      $display("FAIL at_next: got grant=%b atomic=%b ad=%h want 01 0 77",
               bus.grant, bus.mem_atomic, bus.mem_ad);
    else passed++;
    tick();
    tick();
    total++;
    if (bus.done !== 2'b01)
      $display("FAIL at_r0_done: got done=%b want 01", bus.done);
    else passed++;
    clear_reqs();
    tick();
  endtask

  task automatic test_lock_timeout();
    bus.req     = 2'b11;
    bus.lock[1] = 1'b1;
    bus.addr[1] = 20'h00abc;
    bus.addr[0] = 20'h00def;
    mem_val     = 64'h77;
    mem_tagv    = 8'h07;
    tick();
    total++;
    if (bus.grant !== 2'b10)
      $display("FAIL tmo_grant1: got %b want 10", bus.grant);
    else passed++;
    tick();
    tick();
    tick();
    total++;
    if (bus.done !== 2'b10)
      $display("FAIL tmo_rd_done: got %b want 10", bus.done);
    else passed++;
    bus.req[1]  = 1'b0;
    bus.lock[1] = 1'b0;
    tick();
    tick();
    tick();
    total++;
    if (bus.lock_err !== 1'b0 || bus.grant !== 2'b10)
      $display("FAIL tmo_early: got lock_err=%b grant=%b want 0 10", bus.lock_err, bus.grant);
    else passed++;
    tick();
    total++;
    if (bus.lock_err !== 1'b1 || bus.grant !== 2'b00)
      $display("FAIL tmo_err: got lock_err=%b grant=%b want 1 00", bus.lock_err, bus.grant);
    else passed++;
    tick();
    total++;
    if (bus.lock_err !== 1'b0 || bus.grant !== 2'b01 || bus.mem_atomic !== 1'b0)
      $display("FAIL tmo_next: got lock_err=%b grant=%b atomic=%b want 0 01 0",
               bus.lock_err, bus.grant, bus.mem_atomic);
    else passed++;
    tick();
    tick();
    tick();
    total++;
    if (bus.done !== 2'b01)
      $display("FAIL tmo_r0_done: got %b want 01", bus.done);
    else passed++;
    clear_reqs();
    tick();
  endtask

  // Pointer is 1 after requester 0's read is granted; reset must return it to 0.
  task automatic test_reset_mid();
    bus.req[0]  = 1'b1;
    bus.addr[0] = 20'h00321;
    mem_val     = 64'h99;
    mem_tagv    = 8'h09;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    total++;
    if (bus.grant !== 2'b00 || bus.done !== 2'b00 || bus.rdata !== 64'h0 ||
        {bus.mem_astb, bus.mem_rd, bus.mem_wr} !== 3'b000)
      $display("FAIL rst_mid: got grant=%b done=%b rdata=%h strobes=%b want 00 00 0 000",
               bus.grant, bus.done, bus.rdata, {bus.mem_astb, bus.mem_rd, bus.mem_wr});
    else passed++;
    clear_reqs();
    tick();
    total++;
    if (bus.done !== 2'b00)
      $display("FAIL rst_nodone: got %b want 00", bus.done);
    else passed++;
    reset       = 1'b0;
    bus.req     = 2'b11;
    bus.addr[0] = 20'h00111;
    bus.addr[1] = 20'h00222;
    tick();
    total++;
    if (bus.grant !== 2'b01 || bus.mem_ad !== 64'h111 || bus.done !== 2'b00)
      $display("FAIL rst_ptr: got grant=%b ad=%h done=%b want 01 111 00",
               bus.grant, bus.mem_ad, bus.done);
    else passed++;
    bus.req = 2'b01;
    tick();
    tick();
    tick();
    total++;
    if (bus.done !== 2'b01 || bus.rdata !== 64'h99)
      $display("FAIL rst_rd_done: got done=%b rdata=%h want 01 99", bus.done, bus.rdata);
    else passed++;
    clear_reqs();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_single_write();
    test_single_read();
    test_atomic();
    test_lock_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
